clock_ctrl: RTL and testbench

Controller for the HH:MM digital-clock datapath built from four `dig_4` BCD digit counters: minute ones, minute tens, hour ones and hour tens. It counts 1 Hz ticks into seconds and drives per-digit `increase`/`load_def` pulses to advance minutes and hours. It enforces the 59→00 minute wrap and the 23→00 hour wrap, which the 0–9 digit counters cannot do themselves. A mode FSM supports setting hours and minutes from a push button. All digit `def_value` inputs are tied to 4'd0 at top level.

---
 rtl/clock_ctrl_if.sv | 26 ++
 rtl/clock_ctrl.sv | 131 +++++++++++++
 tb/tb_clock_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_ctrl_if.sv
// Bundles the clock controller's event inputs, digit readback and digit-control outputs.
// The controller takes the slave view; whoever drives buttons/ticks and owns the digits takes master.
interface clock_ctrl_if;
  logic       tick;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] min_lo;
  logic [3:0] min_hi;
  logic [3:0] hr_lo;
  logic [3:0] hr_hi;
  logic [3:0] inc;
  logic [3:0] load;
  logic [1:0] mode;
  logic       blink;
  logic [5:0] sec;

  modport master (
    output tick, btn_mode, btn_inc, min_lo, min_hi, hr_lo, hr_hi,
    input  inc, load, mode, blink, sec
  );

  modport slave (
    input  tick, btn_mode, btn_inc, min_lo, min_hi, hr_lo, hr_hi,
    output inc, load, mode, blink, sec
  );
endinterface

// File: rtl/clock_ctrl.sv
// HH:MM clock controller: counts seconds, issues one-cycle increase/load pulses to four
// BCD digit counters (enforcing 59->00 and 23->00) and runs the RUN/SET_HR/SET_MIN mode FSM.
module clock_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  clock_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [5:0] sec_reg, sec_next;
  logic       blink_reg, blink_next;
  logic [3:0] inc_reg, inc_next;
  logic [3:0] load_reg, load_next;

  logic       busy;
  logic       min_carry;
  logic       min_wrap;
  logic       hr_wrap;
  logic [1:0] min_inc, min_load;
  logic [1:0] hr_inc, hr_load;

  // Digit values are stale while a pulse is still being applied by the counters.
  assign busy = (inc_reg != 4'd0);

  assign min_carry = (bus.min_lo >= 4'd9);
  assign min_wrap  = min_carry && (bus.min_hi >= 4'd5);
  assign hr_wrap   = (bus.hr_hi >= 4'd2) && (bus.hr_lo >= 4'd3);

  assign min_inc  = {min_carry, 1'b1};
  assign min_load = {min_wrap, 1'b0};
  assign hr_inc   = hr_wrap ? 2'b11 : {(bus.hr_lo >= 4'd9), 1'b1};
  assign hr_load  = hr_wrap ? 2'b11 : 2'b00;

  always_comb begin
    state_next = state_reg;
    sec_next   = sec_reg;
    blink_next = blink_reg;
    inc_next   = 4'd0;
    load_next  = 4'd0;

    case (state_reg)
      RUN: begin
        if (bus.btn_mode) begin
          state_next = SET_HR;
          sec_next   = 6'd0;
          blink_next = 1'b0;
        end else if (bus.tick) begin
          if (sec_reg >= 6'd59) begin
            sec_next = 6'd0;
            if (!busy) begin
              inc_next  = {2'b00, min_inc};
              load_next = {2'b00, min_load};
              if (min_wrap) begin
                inc_next[3:2]  = hr_inc;
                load_next[3:2] = hr_load;
              end
            end
          end else begin
            sec_next = sec_reg + 6'd1;
          end
        end
      end

      SET_HR: begin
        sec_next = 6'd0;
        if (bus.btn_mode) begin
          state_next = SET_MIN;
          blink_next = 1'b0;
        end else begin
          if (bus.tick)
            blink_next = ~blink_reg;
          if (bus.btn_inc && !busy) begin
            inc_next  = {hr_inc, 2'b00};
            load_next = {hr_load, 2'b00};
          end
        end
      end

      SET_MIN: begin
        sec_next = 6'd0;
        if (bus.btn_mode) begin
          state_next = RUN;
          blink_next = 1'b0;
        end else begin
          if (bus.tick)
            blink_next = ~blink_reg;
          if (bus.btn_inc && !busy) begin
            inc_next  = {2'b00, min_inc};
            load_next = {2'b00, min_load};
          end
        end
      end

      default: begin
        state_next = RUN;
        sec_next   = 6'd0;
        blink_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      sec_reg   <= 6'd0;
      blink_reg <= 1'b0;
      inc_reg   <= 4'd0;
      load_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      sec_reg   <= sec_next;
      blink_reg <= blink_next;
      inc_reg   <= inc_next;
      load_reg  <= load_next;
    end
  end

  assign bus.inc   = inc_reg;
  assign bus.load  = load_reg;
  assign bus.mode  = state_reg;
  assign bus.blink = blink_reg;
  assign bus.sec   = sec_reg;

endmodule

// File: tb/tb_clock_ctrl.sv
// Testbench for clock_ctrl: models the four digit counters and predicts the clock from
// hour/minute arithmetic, checking directed scenarios and a randomized event stream.
module tb_clock_ctrl;

  logic clk;
  logic rst_n;
  clock_ctrl_if bus();

  clock_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Digit counter models (value 0-9, wrap 9->0, load_def to 0 when qualified by increase)
  logic [3:0] dig [4];
  logic [3:0] preset_dig [4];
  logic       preset_en;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) dig[i] <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (preset_en)
          dig[i] <= preset_dig[i];
        else if (bus.inc[i])
          dig[i] <= bus.load[i] ? 4'd0 : ((dig[i] == 4'd9) ? 4'd0 : dig[i] + 4'd1);
      end
    end
  end

  assign bus.min_lo = dig[0];
  assign bus.min_hi = dig[1];
  assign bus.hr_lo  = dig[2];
  assign bus.hr_hi  = dig[3];

  // Reference model: time as plain integers
  int         hh, mm, m_sec, m_mode;
  bit         m_blink;
  logic [3:0] m_inc, m_load;
  bit         pend_valid;
  int         pend_hh, pend_mm;

  task automatic model_reset();
    hh = 0; mm = 0; m_sec = 0; m_mode = 0; m_blink = 0;
    m_inc = 4'd0; m_load = 4'd0; pend_valid = 0; pend_hh = 0; pend_mm = 0;
  endtask

  task automatic hour_adv();
    if (hh == 23) begin
      m_inc[3:2] = 2'b11; m_load[3:2] = 2'b11;
    end else begin
      m_inc[2] = 1'b1;
      if (hh % 10 == 9) m_inc[3] = 1'b1;
    end
    pend_hh = (hh + 1) % 24;
    pend_valid = 1;
  endtask

  task automatic min_adv(input bit carry);
    m_inc[0] = 1'b1;
    if (mm % 10 == 9) m_inc[1] = 1'b1;
    if (mm == 59) m_load[1] = 1'b1;
    pend_mm = (mm + 1) % 60;
    pend_valid = 1;
    if (carry && mm == 59) hour_adv();
  endtask

  // Drive one cycle of events, advance past the edge, then update the model.
  task automatic step(input bit t, input bit bm, input bit bi);
    bit busy;
    bus.tick = t; bus.btn_mode = bm; bus.btn_inc = bi;
    @(posedge clk); #1;
    bus.tick = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
    busy = (m_inc != 4'd0);
    if (pend_valid) begin
      hh = pend_hh; mm = pend_mm; pend_valid = 0;
    end
    pend_hh = hh; pend_mm = mm;
    m_inc = 4'd0; m_load = 4'd0;
    if (bm) begin
      m_mode = (m_mode + 1) % 3; m_sec = 0; m_blink = 0;
    end else begin
      case (m_mode)
        0: if (t) begin
             if (m_sec == 59) begin m_sec = 0; min_adv(1); end
             else m_sec = m_sec + 1;
           end
        1: begin
             if (t) m_blink = ~m_blink;
             if (bi && !busy) hour_adv();
           end
        default: begin
             if (t) m_blink = ~m_blink;
             if (bi && !busy) min_adv(0);
           end
      endcase
    end
  endtask

  task automatic preset(input int h, input int m);
    preset_dig[0] = 4'(m % 10); preset_dig[1] = 4'(m / 10);
    preset_dig[2] = 4'(h % 10); preset_dig[3] = 4'(h / 10);
    preset_en = 1'b1;
    step(0, 0, 0);
    preset_en = 1'b0;
    hh = h; mm = m;
  endtask

  task automatic run_to_sec59();
    int guard = 0;
    while (m_sec != 59 && guard < 200) begin
      step(1, 0, 0);
      guard++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d exp 0", bus.mode); end
    checks++; if (bus.sec !== 6'd0) begin errors++; $display("FAIL reset_sec got %0d exp 0", bus.sec); end
    checks++; if (bus.inc !== 4'd0 || bus.load !== 4'd0) begin errors++; $display("FAIL reset_pulse got inc=%b load=%b exp 0000/0000", bus.inc, bus.load); end
    checks++; if (bus.blink !== 1'b0) begin errors++; $display("FAIL reset_blink got %b exp 0", bus.blink); end
    rst_n = 1'b1;
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    checks++; if (bus.sec !== 6'd3) begin errors++; $display("FAIL count_sec got %0d exp 3", bus.sec); end
    checks++; if (bus.inc !== 4'd0) begin errors++; $display("FAIL count_inc got %b exp 0000", bus.inc); end
    $display("test_reset: sec=%0d inc=%b", bus.sec, bus.inc);
  endtask

  task automatic test_rollover();
    preset(12, 59);
    run_to_sec59();
    checks++; if (bus.sec !== 6'd59) begin errors++; $display("FAIL roll_pre_sec got %0d exp 59", bus.sec); end
    step(1, 0, 0);
    checks++; if (bus.inc !== 4'b0111 || bus.load !== 4'b0010) begin errors++; $display("FAIL roll_pulse got inc=%b load=%b exp 0111/0010", bus.inc, bus.load); end
    checks++; if (bus.sec !== 6'd0) begin errors++; $display("FAIL roll_sec got %0d exp 0", bus.sec); end
    step(0, 0, 0);
    checks++; if ({dig[3], dig[2], dig[1], dig[0]} !== 16'h1300) begin errors++; $display("FAIL roll_time got %h exp 1300", {dig[3], dig[2], dig[1], dig[0]}); end
    checks++; if (bus.inc !== 4'd0) begin errors++; $display("FAIL roll_single got inc=%b exp 0000", bus.inc); end
    $display("test_rollover: time=%h", {dig[3], dig[2], dig[1], dig[0]});
  endtask

  task automatic test_day_wrap();
    preset(23, 59);
    run_to_sec59();
    step(1, 0, 0);
    checks++; if (bus.inc !== 4'b1111 || bus.load !== 4'b1110) begin errors++; $display("FAIL wrap_pulse got inc=%b load=%b exp 1111/1110", bus.inc, bus.load); end
    step(0, 0, 0);
    checks++; if ({dig[3], dig[2], dig[1], dig[0]} !== 16'h0000) begin errors++; $display("FAIL wrap_time got %h exp 0000", {dig[3], dig[2], dig[1], dig[0]}); end
    $display("test_day_wrap: time=%h", {dig[3], dig[2], dig[1], dig[0]});
  endtask

  task automatic test_set_hr();
    step(1, 0, 0);
    step(0, 1, 0);
    checks++; if (bus.mode !== 2'd1 || bus.sec !== 6'd0) begin errors++; $display("FAIL sethr_enter got mode=%0d sec=%0d exp 1/0", bus.mode, bus.sec); end
    preset(23, 45);
    step(0, 0, 1);
    checks++; if (bus.inc !== 4'b1100 || bus.load !== 4'b1100) begin errors++; $display("FAIL sethr_pulse got inc=%b load=%b exp 1100/1100", bus.inc, bus.load); end
    step(0, 0, 0);
    checks++; if ({dig[3], dig[2], dig[1], dig[0]} !== 16'h0045) begin errors++; $display("FAIL sethr_time got %h exp 0045", {dig[3], dig[2], dig[1], dig[0]}); end
    step(1, 0, 0);
    checks++; if (bus.blink !== 1'b1) begin errors++; $display("FAIL sethr_blink1 got %b exp 1", bus.blink); end
    step(0, 0, 0);
    step(1, 0, 0);
    checks++; if (bus.blink !== 1'b0) begin errors++; $display("FAIL sethr_blink0 got %b exp 0", bus.blink); end
    $display("test_set_hr: time=%h blink=%b", {dig[3], dig[2], dig[1], dig[0]}, bus.blink);
  endtask

  task automatic test_set_min();
    step(1, 0, 0);
    step(0, 1, 0);
    checks++; if (bus.mode !== 2'd2 || bus.blink !== 1'b0) begin errors++; $display("FAIL setmin_enter got mode=%0d blink=%b exp 2/0", bus.mode, bus.blink); end
    preset(7, 59);
    step(0, 0, 1);
    checks++; if (bus.inc !== 4'b0011 || bus.load !== 4'b0010) begin errors++; $display("FAIL setmin_pulse got inc=%b load=%b exp 0011/0010", bus.inc, bus.load); end
    step(0, 0, 1);
    checks++; if (bus.inc !== 4'd0) begin errors++; $display("FAIL setmin_busy_drop got inc=%b exp 0000", bus.inc); end
    step(0, 0, 0);
    checks++; if ({dig[3], dig[2], dig[1], dig[0]} !== 16'h0700) begin errors++; $display("FAIL setmin_time got %h exp 0700", {dig[3], dig[2], dig[1], dig[0]}); end
    step(0, 1, 1);
    checks++; if (bus.mode !== 2'd0 || bus.inc !== 4'd0 || bus.sec !== 6'd0) begin errors++; $display("FAIL setmin_prio got mode=%0d inc=%b sec=%0d exp 0/0000/0", bus.mode, bus.inc, bus.sec); end
    $display("test_set_min: time=%h mode=%0d", {dig[3], dig[2], dig[1], dig[0]}, bus.mode);
  endtask

  task automatic test_random();
    int nerr = 0;
    logic [3:0] prev_inc = 4'd0;
    preset($urandom_range(23, 0), $urandom_range(59, 0));
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(1, 0) == 1, $urandom_range(23, 0) == 0, $urandom_range(2, 0) == 0);
      checks++; if (bus.mode !== 2'(m_mode)) begin errors++; nerr++; $display("FAIL rnd_mode cyc %0d got %0d exp %0d", n, bus.mode, m_mode); end
      checks++; if (bus.sec !== 6'(m_sec)) begin errors++; nerr++; $display("FAIL rnd_sec cyc %0d got %0d exp %0d", n, bus.sec, m_sec); end
      checks++; if (bus.blink !== m_blink) begin errors++; nerr++; $display("FAIL rnd_blink cyc %0d got %b exp %b", n, bus.blink, m_blink); end
      checks++; if (bus.inc !== m_inc || bus.load !== m_load) begin errors++; nerr++; $display("FAIL rnd_pulse cyc %0d got %b/%b exp %b/%b", n, bus.inc, bus.load, m_inc, m_load); end
      checks++; if (dig[0] !== 4'(mm % 10) || dig[1] !== 4'(mm / 10) || dig[2] !== 4'(hh % 10) || dig[3] !== 4'(hh / 10)) begin
        errors++; nerr++; $display("FAIL rnd_time cyc %0d got %h exp %02d%02d", n, {dig[3], dig[2], dig[1], dig[0]}, hh, mm);
      end
      checks++; if (bus.inc !== 4'd0 && prev_inc !== 4'd0) begin errors++; nerr++; $display("FAIL rnd_glitch cyc %0d got %b after %b exp 0000", n, bus.inc, prev_inc); end
      prev_inc = bus.inc;
    end
    // Return to RUN for the following test
    while (m_mode != 0) step(0, 1, 0);
    $display("test_random: 600 cycles, %0d discrepancies", nerr);
  endtask

  task automatic test_reset_mid();
    preset(23, 59);
    run_to_sec59();
    step(1, 0, 0);
    checks++; if (bus.inc !== 4'b1111) begin errors++; $display("FAIL mid_pulse got inc=%b exp 1111", bus.inc); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.inc !== 4'd0 || bus.load !== 4'd0 || bus.mode !== 2'd0) begin errors++; $display("FAIL mid_async got inc=%b load=%b mode=%0d exp 0000/0000/0", bus.inc, bus.load, bus.mode); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 3; n++) begin
      step(0, 0, 0);
      checks++; if (bus.inc !== 4'd0) begin errors++; $display("FAIL mid_after got inc=%b exp 0000", bus.inc); end
    end
    checks++; if ({dig[3], dig[2], dig[1], dig[0]} !== 16'h0000) begin errors++; $display("FAIL mid_time got %h exp 0000", {dig[3], dig[2], dig[1], dig[0]}); end
    $display("test_reset_mid: inc=%b time=%h", bus.inc, {dig[3], dig[2], dig[1], dig[0]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus.tick = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
    preset_en = 1'b0;
    for (int i = 0; i < 4; i++) preset_dig[i] = 4'd0;
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_rollover();
    test_day_wrap();
    test_set_hr();
    test_set_min();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
